// File: rtl/game_round_ctrl.sv
// Game session sequencer: seeds an LFSR, lights pseudo-random targets for a
// bounded number of game ticks, scores hits and ends the game after too many misses.
module game_round_ctrl #(
  parameter int TGT_W      = 3,
  parameter int SHOW_TICKS = 4,
  parameter int MAX_MISS   = 3,
  parameter int SCORE_W    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               upd,
  input  logic [24:0]        seed,
  input  logic               start,
  input  logic               hit,
  input  logic [TGT_W-1:0]   hit_idx,
  output logic               target_on,
  output logic [TGT_W-1:0]   target_idx,
  output logic [SCORE_W-1:0] score,
  output logic [3:0]         misses,
  output logic               busy,
  output logic               game_over
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_PICK = 3'd2;
  localparam logic [2:0] S_SHOW = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_OVER = 3'd5;

  localparam logic [15:0] LFSR_INIT = 16'hACE1;
  localparam logic [3:0]  LAST_TICK = 4'(SHOW_TICKS - 1);
  localparam logic [3:0]  MISS_END  = 4'(MAX_MISS);

  logic [2:0]  state;
  logic [15:0] lfsr, lfsr_next, seed_ld;
  logic        upd_q, tick, correct;
  logic [3:0]  tcnt, miss_inc;
  logic        unused_seed;

  // Both edges of the slow update level count as one game tick.
  assign tick      = upd ^ upd_q;
  assign lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  assign seed_ld   = (seed[15:0] == 16'h0000) ? LFSR_INIT : seed[15:0];
  assign correct   = hit && (hit_idx == target_idx);
  assign miss_inc  = misses + 4'd1;
  assign unused_seed = ^seed[24:16];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      lfsr       <= LFSR_INIT;
      upd_q      <= 1'b0;
      tcnt       <= 4'd0;
      target_on  <= 1'b0;
      target_idx <= '0;
      score      <= '0;
      misses     <= 4'd0;
      busy       <= 1'b0;
      game_over  <= 1'b0;
    end else begin
      upd_q <= upd;
      case (state)
        S_IDLE: if (start) state <= S_LOAD;
        S_LOAD: begin
          lfsr      <= seed_ld;
          score     <= '0;
          misses    <= 4'd0;
          game_over <= 1'b0;
          busy      <= 1'b1;
          state     <= S_PICK;
        end
        S_PICK: begin
          lfsr       <= lfsr_next;
          target_idx <= lfsr_next[15 -: TGT_W];
          tcnt       <= 4'd0;
          target_on  <= 1'b1;
          state      <= S_SHOW;
        end
        S_SHOW: begin
          // A correct hit beats a timeout tick arriving in the same cycle.
          if (correct) begin
            if (score != '1) score <= score + SCORE_W'(1);
            target_on <= 1'b0;
            state     <= S_GAP;
          end else if (tick) begin
            if (tcnt == LAST_TICK) begin
              misses    <= miss_inc;
              target_on <= 1'b0;
              if (miss_inc == MISS_END) begin
                game_over <= 1'b1;
                busy      <= 1'b0;
                state     <= S_OVER;
              end else begin
                state <= S_GAP;
              end
            end else begin
              tcnt <= tcnt + 4'd1;
            end
          end
        end
        S_GAP:  if (tick) state <= S_PICK;
        S_OVER: if (start) state <= S_LOAD;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_game_round_ctrl.sv
// Randomized bench for game_round_ctrl against a rule-level session model;
// a second instance with a 2-bit score exercises saturation.
module tb_game_round_ctrl;

  logic        clk = 1'b0;
  logic        rst_n, upd, start, hit;
  logic [2:0]  hit_idx;
  logic [24:0] seed;

  logic       target_on, busy, game_over;
  logic [2:0] target_idx;
  logic [7:0] score;
  logic [3:0] misses;

  logic       target_on2, busy2, game_over2;
  logic [2:0] target_idx2;
  logic [1:0] score2;
  logic [3:0] misses2;

  int total = 0;
  int bad   = 0;

  game_round_ctrl #(.TGT_W(3), .SHOW_TICKS(4), .MAX_MISS(3), .SCORE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .upd(upd), .seed(seed), .start(start), .hit(hit),
    .hit_idx(hit_idx), .target_on(target_on), .target_idx(target_idx), .score(score),
    .misses(misses), .busy(busy), .game_over(game_over));

  game_round_ctrl #(.TGT_W(3), .SHOW_TICKS(4), .MAX_MISS(3), .SCORE_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .upd(upd), .seed(seed), .start(start), .hit(hit),
    .hit_idx(hit_idx), .target_on(target_on2), .target_idx(target_idx2), .score(score2),
    .misses(misses2), .busy(busy2), .game_over(game_over2));

  always #5 clk = ~clk;

  // Session model: phase names only, counts kept as plain integers.
  localparam int P_IDLE = 0, P_LOAD = 1, P_PICK = 2, P_SHOW = 3, P_GAP = 4, P_OVER = 5;
  int          m_ph, m_ticks, m_score, m_score2, m_miss;
  logic [15:0] m_lfsr;
  logic        m_updq, m_on, m_busy, m_over;
  logic [2:0]  m_tgt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = P_IDLE; m_lfsr = 16'hACE1; m_updq = 1'b0; m_ticks = 0;
    m_on = 1'b0; m_tgt = 3'd0; m_score = 0; m_score2 = 0; m_miss = 0;
    m_busy = 1'b0; m_over = 1'b0;
  endtask

  task automatic model_step();
    logic tk;
    tk = upd ^ m_updq;
    m_updq = upd;
    case (m_ph)
      P_IDLE: if (start) m_ph = P_LOAD;
      P_LOAD: begin
        m_lfsr = (seed[15:0] == 16'h0) ? 16'hACE1 : seed[15:0];
        m_score = 0; m_score2 = 0; m_miss = 0; m_over = 1'b0; m_busy = 1'b1;
        m_ph = P_PICK;
      end
      P_PICK: begin
        m_lfsr = (m_lfsr >> 1) ^ ((m_lfsr % 2 == 1) ? 16'hB400 : 16'h0000);
        m_tgt = 3'(m_lfsr >> 13);
        m_ticks = 0; m_on = 1'b1; m_ph = P_SHOW;
      end
      P_SHOW: begin
        if (hit && hit_idx == m_tgt) begin
          if (m_score < 255) m_score++;
          if (m_score2 < 3) m_score2++;
          m_on = 1'b0; m_ph = P_GAP;
        end else if (tk) begin
          m_ticks++;
          if (m_ticks == 4) begin
            m_miss++; m_on = 1'b0;
            if (m_miss == 3) begin m_over = 1'b1; m_busy = 1'b0; m_ph = P_OVER; end
            else m_ph = P_GAP;
          end
        end
      end
      P_GAP:  if (tk) m_ph = P_PICK;
      default: if (start) m_ph = P_LOAD;
    endcase
  endtask

  task automatic check_all();
    chk("target_on",  32'(target_on),  32'(m_on));
    chk("target_idx", 32'(target_idx), 32'(m_tgt));
    chk("score",      32'(score),      32'(m_score));
    chk("misses",     32'(misses),     32'(m_miss));
    chk("busy",       32'(busy),       32'(m_busy));
    chk("game_over",  32'(game_over),  32'(m_over));
    chk("score_w2",   32'(score2),     32'(m_score2));
  endtask

  // Drive at the falling edge, let the model see the rising edge, check at the next fall.
  task automatic cyc(input logic s, input logic u, input logic h, input logic [2:0] hi,
                     input logic [24:0] sd);
    start = s; upd = u; hit = h; hit_idx = hi; seed = sd;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic rand_cyc();
    logic [2:0] hi;
    hi = ($urandom_range(0, 2) == 0) ? m_tgt : 3'($urandom_range(0, 7));
    cyc(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0) ? ~upd : upd,
        ($urandom_range(0, 3) == 0), hi, 25'($urandom));
  endtask

  initial begin
    bit found;
    rst_n = 1'b0; upd = 1'b0; start = 1'b0; hit = 1'b0; hit_idx = 3'd0; seed = 25'd0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all();
    rst_n = 1'b1;

    // Seed 1: first target B400 -> index 5, then 5A00 -> index 2.
    cyc(1'b1, upd, 1'b0, 3'd0, 25'h0000001);
    cyc(1'b0, upd, 1'b0, 3'd0, 25'h0000001);
    chk("plan_busy_e1", 32'(busy), 32'd1);
    cyc(1'b0, upd, 1'b0, 3'd0, 25'h0000001);
    chk("plan_on_e2", 32'(target_on), 32'd1);
    chk("plan_idx5", 32'(target_idx), 32'd5);
    cyc(1'b0, upd, 1'b1, 3'd5, 25'h0000001);
    chk("plan_score1", 32'(score), 32'd1);
    cyc(1'b0, ~upd, 1'b0, 3'd0, 25'h0000001);
    cyc(1'b0, upd, 1'b0, 3'd0, 25'h0000001);
    chk("plan_idx2", 32'(target_idx), 32'd2);

    // Let every target time out until the game ends.
    for (int i = 0; i < 40; i++) cyc(1'b0, ~upd, 1'b0, 3'd0, 25'h0);
    chk("plan_over", 32'(game_over), 32'd1);
    chk("plan_miss3", 32'(misses), 32'd3);

    // Seed 0 falls back to ACE1 -> first target E270, index 7.
    cyc(1'b1, upd, 1'b0, 3'd0, 25'h0);
    cyc(1'b0, upd, 1'b0, 3'd0, 25'h0);
    cyc(1'b0, upd, 1'b0, 3'd0, 25'h0);
    chk("plan_idx7", 32'(target_idx), 32'd7);
    cyc(1'b0, upd, 1'b1, m_tgt ^ 3'd1, 25'h0);
    chk("wrong_hit_on", 32'(target_on), 32'd1);
    for (int i = 0; i < 3; i++) cyc(1'b0, ~upd, 1'b0, 3'd0, 25'h0);
    cyc(1'b0, ~upd, 1'b1, m_tgt, 25'h0);
    chk("hit_wins_miss", 32'(misses), 32'd0);
    chk("hit_wins_score", 32'(score), 32'd1);

    // Hit every target so the 2-bit score saturates.
    for (int i = 0; i < 120; i++) begin
      if (m_ph == P_SHOW) cyc(1'b0, ~upd, 1'b1, m_tgt, 25'h0);
      else cyc(1'b0, ~upd, 1'b0, 3'd0, 25'h0);
    end
    chk("sat_w2", 32'(score2), 32'd3);

    for (int i = 0; i < 3000; i++) rand_cyc();

    // Asynchronous reset while a target is lit.
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      rand_cyc();
      if (m_ph == P_SHOW) found = 1'b1;
    end
    chk("wait_show", 32'(found), 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("async_rst_outs", {26'(target_on), 3'(target_idx), 8'(score), 4'(misses),
                               1'(busy), 1'(game_over)}, 32'd0);
    model_reset();
    check_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b1, upd, 1'b0, 3'd0, 25'h00ABCDE);
    cyc(1'b0, upd, 1'b0, 3'd0, 25'h00ABCDE);
    chk("rst_new_busy", 32'(busy), 32'd1);
    for (int i = 0; i < 200; i++) rand_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
